// File: rtl/reg_bank.sv
// Two-read/one-write architectural register file with register 0 hardwired to zero.
// Reads are combinational, with optional same-cycle forwarding from the write port.
module reg_bank #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  input  logic [AW-1:0]    rd,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  output logic             wr_ack
);

  localparam bit FWD = (BYPASS != 0);

  logic [WIDTH-1:0] regs [NREG];
  logic             wr_commit;

  // A write to address 0 is discarded; reset is handled separately in the register process.
  assign wr_commit = wr_en && (rd != '0);

  // Storage and write acknowledge; reset takes priority over any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_commit;
      if (wr_commit) begin
        regs[rd] <= wr_data;
      end
    end
  end

  // Forwarding is not gated by rst, so outputs still see the write data in a reset cycle.
  always_comb begin
    rs_data = (rs == '0) ? '0 : regs[rs];
    rt_data = (rt == '0) ? '0 : regs[rt];
    if (FWD && wr_commit && (rd == rs)) begin
      rs_data = wr_data;
    end
    if (FWD && wr_commit && (rd == rt)) begin
      rt_data = wr_data;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: a forwarding instance and a non-forwarding instance
// share the same stimulus and are compared against a reference array model.
module tb_reg_bank;

  typedef struct {
    logic [31:0] rs_a;
    logic [31:0] rt_a;
    logic [31:0] rs_b;
    logic [31:0] rt_b;
    logic        ack;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  rs, rt, rd;
  logic [31:0] wr_data;
  logic [31:0] a_rs, a_rt, b_rs, b_rt;
  logic        a_ack, b_ack;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [32];
  logic        ack_m;
  exp_t        sb [$];

  reg_bank #(.WIDTH(32), .NREG(32), .AW(5), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .wr_en(wr_en),
    .wr_data(wr_data), .rs_data(a_rs), .rt_data(a_rt), .wr_ack(a_ack)
  );

  reg_bank #(.WIDTH(32), .NREG(32), .AW(5), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .wr_en(wr_en),
    .wr_data(wr_data), .rs_data(b_rs), .rt_data(b_rt), .wr_ack(b_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, predict, sample mid-low-phase, update model at posedge.
  task automatic step(input logic r, input logic we, input logic [4:0] d,
                      input logic [31:0] wd, input logic [4:0] s, input logic [4:0] t);
    exp_t e;
    @(negedge clk);
    rst = r; wr_en = we; rd = d; wr_data = wd; rs = s; rt = t;
    e.rs_b = (s == 5'd0) ? 32'h0 : mem[s];
    e.rt_b = (t == 5'd0) ? 32'h0 : mem[t];
    e.rs_a = (we && d != 5'd0 && d == s) ? wd : e.rs_b;
    e.rt_a = (we && d != 5'd0 && d == t) ? wd : e.rt_b;
    e.ack  = ack_m;
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk("rs_data_bypass", a_rs, e.rs_a);
      chk("rt_data_bypass", a_rt, e.rt_a);
      chk("rs_data_nobypass", b_rs, e.rs_b);
      chk("rt_data_nobypass", b_rt, e.rt_b);
      chk("wr_ack_bypass", {31'h0, a_ack}, {31'h0, e.ack});
      chk("wr_ack_nobypass", {31'h0, b_ack}, {31'h0, e.ack});
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      ack_m = 1'b0;
    end else begin
      ack_m = we && (d != 5'd0);
      if (ack_m) mem[d] = wd;
    end
  endtask

  initial begin
    logic [4:0]  rs_r, rt_r, rd_r;
    logic [31:0] wd_r;
    logic        we_r, rst_r;

    rst = 1'b1; wr_en = 1'b0; rd = '0; wr_data = '0; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    ack_m = 1'b0;

    // Every address reads zero after reset.
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

    // Single write, read back on both ports, ack for one cycle.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

    // Writes to r0 are discarded and never forwarded.
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Forwarding versus stored value on the same-cycle write.
    step(1'b0, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

    // Back-to-back writes to one register; last wins, two ack pulses.
    step(1'b0, 1'b1, 5'd9, 32'h1, 5'd9, 5'd0);
    step(1'b0, 1'b1, 5'd9, 32'h2, 5'd0, 5'd9);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);

    // Full-width value through port B is returned untouched.
    step(1'b0, 1'b1, 5'd12, 32'hFFFFFFFF, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd12);

    // Reset mid-operation beats a concurrent write and clears everything.
    step(1'b0, 1'b1, 5'd31, 32'h80000000, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd3, 32'h5, 5'd31, 5'd3);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd3);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);

    // Random traffic, biased so reads often hit the write address.
    for (int n = 0; n < 1000; n++) begin
      rst_r = ($urandom_range(0, 99) == 0);
      we_r  = 1'($urandom_range(0, 1));
      rd_r  = 5'($urandom);
      wd_r  = $urandom;
      rs_r  = ($urandom_range(0, 3) == 0) ? rd_r : 5'($urandom);
      rt_r  = ($urandom_range(0, 3) == 0) ? rd_r : 5'($urandom);
      step(rst_r, we_r, rd_r, wd_r, rs_r, rt_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter WIDTH, default 32, is the data width of every register and data port.
REQ-002 Parameter NREG, default 32, is the number of architectural registers and SHALL be a power of two.
REQ-003 Parameter AW, default 5, is the address width and SHALL equal log2(NREG).
REQ-004 Parameter BYPASS, default 1: 1 enables write-to-read forwarding in the same cycle; 0 returns the pre-write contents.
REQ-005 The block SHALL have one clock, clk; reset, rst, is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 rs  input  AW  read address, port A (first ALU operand).
REQ-009 rt  input  AW  read address, port B (second operand / shift amount).
REQ-010 rd  input  AW  write address.
REQ-011 wr_en  input  1  write enable.
REQ-012 wr_data  input  WIDTH  write data.
REQ-013 rs_data  output  WIDTH  port A read data.
REQ-014 rt_data  output  WIDTH  port B read data.
REQ-015 wr_ack  output  1  registered, high for one cycle after each committed write.

Function
REQ-016 Storage: NREG x WIDTH registers, addressed 0..NREG-1.
REQ-017 Reads: combinational, zero latency; rs_data and rt_data reflect the current addresses and contents in the same cycle.
REQ-018 Register 0 is hardwired to zero: reads of address 0 always return 0, and writes to rd=0 are discarded.
REQ-019 Write commits on the rising clk edge when wr_en=1, rst=0 and rd!=0; the new value is visible to combinational reads after that edge.
REQ-020 Bypass (BYPASS=1): when wr_en=1, rd!=0 and rd==rs, rs_data SHALL equal wr_data in that cycle; the same rule applies to rt/rt_data, and both ports may be forwarded at once.
REQ-021 Bypass is disabled (BYPASS=0): read data SHALL be the stored value until the write edge.
REQ-022 No forwarding when rd=0, even with wr_en=1.
REQ-023 wr_ack SHALL be 1 in the cycle following an edge that committed a write, and 0 otherwise, including after discarded rd=0 writes.
REQ-024 Back-to-back writes to the same rd on consecutive cycles: the last write wins; each write produces its own wr_ack pulse.
REQ-025 Only one write port exists, so there is no write-write conflict; unknown (X) addresses need not be handled.
REQ-026 The rt_data value is consumed unmodified by the downstream shifter; the block SHALL NOT truncate or sign-process it.

Reset
REQ-027 When rst=1 at a rising edge, all NREG registers SHALL be cleared to 0 and wr_ack SHALL be cleared to 0.
REQ-028 rst has priority over wr_en: a write presented during a reset cycle is discarded and produces no wr_ack.
REQ-029 During reset, reads SHALL continue to be combinational; with BYPASS=1, forwarding still applies to the outputs in the reset cycle, but nothing is stored.
REQ-030 Reset asserted mid-operation, after writes, returns every register to 0 on the next edge.

Verification
REQ-031 Reset then read all addresses -> every rs_data and rt_data is 0x00000000; wr_ack is 0.
REQ-032 Write rd=5, 0xDEADBEEF; next cycle rs=5, rt=5 -> both outputs are 0xDEADBEEF, and wr_ack=1 for exactly one cycle.
REQ-033 wr_en=1, rd=0, 0xFFFFFFFF; rs=0 in the same and next cycle -> rs_data=0 in both, and wr_ack stays 0.
REQ-034 BYPASS=1: r7=0x11 stored, then wr_en=1, rd=7, 0x22 with rs=7, rt=7 -> both read 0x22 in that cycle; with BYPASS=0 both read 0x11 in that cycle and 0x22 next.
REQ-035 Write r31=0x80000000, then rst=1 together with wr_en=1, rd=3, 0x5 -> afterwards r31=0, r3=0, and wr_ack=0.
REQ-036 Random sequence of 1000 cycles with random rs/rt/rd/wr_en against a reference array model -> no mismatch on any read port in any cycle.
